// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies a synchronised lock,
// and holds downstream logic in reset until lock has been stable long enough.
module pll_lock_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int LOCK_STABLE    = 1024,
  parameter int MAX_RETRIES    = 4,
  parameter int RETRY_W        = 3
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_count
);

  localparam int CNT_MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX    = (CNT_MAX_AB > LOCK_STABLE) ? CNT_MAX_AB : LOCK_STABLE;
  localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [RETRY_W-1:0] retry_nxt;
  logic               lock_meta, lock_s;

  // pll_locked is asynchronous to refclk; only the second flop is used by the FSM.
  always_ff @(posedge refclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its inputs, independent of statement order.
    if (rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

  always_comb begin
    // NOTE: every combinational output is given a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    retry_nxt = retry_count;

    unique case (state)
      S_RESET_PLL: begin
        if (cnt == RST_LAST) state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = S_STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          if (retry_count == RETRY_LIMIT) begin
            state_nxt = S_FAIL;
          end else begin
            state_nxt = S_RESET_PLL;
            retry_nxt = retry_count + RETRY_W'(1);
          end
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_nxt = S_WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = S_RUN;
          retry_nxt = '0;
        end
      end
      S_RUN: begin
        cnt_nxt = '0;
        if (!lock_s) state_nxt = S_RESET_PLL;
      end
      S_FAIL: begin
        cnt_nxt = '0;
      end
      default: begin
        state_nxt = S_RESET_PLL;
      end
    endcase

    // One shared counter restarts on every state change.
    if (state_nxt != state) cnt_nxt = '0;
  end

  // Outputs are decoded from the next state so they change on the same edge as state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state       <= S_RESET_PLL;
      cnt         <= '0;
      retry_count <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      retry_count <= retry_nxt;
      pll_rst     <= (state_nxt == S_RESET_PLL) || (state_nxt == S_FAIL);
      sys_rst     <= (state_nxt != S_RUN);
      ready       <= (state_nxt == S_RUN);
      fail        <= (state_nxt == S_FAIL);
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short timing parameters; expected
// edge counts and pulse lengths are worked out by hand from the state sequence.
module tb_pll_lock_sequencer;

  localparam int PLL_RST_CYCLES = 4;
  localparam int LOCK_TIMEOUT   = 20;
  localparam int LOCK_STABLE    = 8;
  localparam int MAX_RETRIES    = 2;
  localparam int RETRY_W        = 3;

  logic               refclk = 1'b0;
  logic               rst = 1'b1;
  logic               pll_locked = 1'b0;
  logic               pll_rst, sys_rst, ready, fail;
  logic [RETRY_W-1:0] retry_count;

  int n_tests = 0;
  int n_fail  = 0;

  pll_lock_sequencer #(
    .PLL_RST_CYCLES(PLL_RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .LOCK_STABLE   (LOCK_STABLE),
    .MAX_RETRIES   (MAX_RETRIES),
    .RETRY_W       (RETRY_W)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .fail       (fail),
    .retry_count(retry_count)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pll_rst"}, int'(pll_rst), 1);
    check({tag, "_sys_rst"}, int'(sys_rst), 1);
    check({tag, "_ready"},   int'(ready),   0);
    check({tag, "_fail"},    int'(fail),    0);
    check({tag, "_retry"},   int'(retry_count), 0);
  endtask

  // Length in cycles of the pll_rst pulse being observed now.
  task automatic measure_pulse(output int len);
    len = int'(pll_rst);
    for (int i = 0; i < 100 && pll_rst; i++) begin
      step();
      if (pll_rst) len++;
    end
  endtask

  // Edges taken until ready is seen high (bounded).
  task automatic wait_ready(output int edges);
    edges = 0;
    do begin
      step();
      edges++;
    end while (!ready && edges < 200);
  endtask

  int len, edges, mism, exp_rst;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Test 1: clean acquisition
    pll_locked = 1'b0;
    do_reset();
    check_reset_values("t1_reset");
    measure_pulse(len);
    check("t1_pll_rst_len", len, 4);
    step(6);
    pll_locked = 1'b1;
    wait_ready(edges);
    check("t1_lock_to_ready", edges, 11);
    check("t1_sys_rst", int'(sys_rst), 0);
    check("t1_retry", int'(retry_count), 0);

    // Test 4: lock loss in RUN
    pll_locked = 1'b0;
    step(2);
    check("t4_ready_edge2", int'(ready), 1);
    check("t4_sys_rst_edge2", int'(sys_rst), 0);
    step();
    check("t4_sys_rst_edge3", int'(sys_rst), 1);
    check("t4_ready_edge3", int'(ready), 0);
    check("t4_pll_rst_edge3", int'(pll_rst), 1);
    measure_pulse(len);
    check("t4_pll_rst_len", len, 4);
    pll_locked = 1'b1;
    wait_ready(edges);
    check("t4_relock_to_ready", edges, 11);
    check("t4_retry", int'(retry_count), 0);

    // Test 3: one-cycle lock glitch in STABLE after one timeout
    pll_locked = 1'b0;
    do_reset();
    step(28);
    check("t3_retry_before", int'(retry_count), 1);
    check("t3_in_wait", int'(pll_rst), 0);
    pll_locked = 1'b1;
    step(8);
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    step(2);
    check("t3_ready_after_glitch", int'(ready), 0);
    check("t3_retry_after_glitch", int'(retry_count), 1);
    wait_ready(edges);
    check("t3_restore_to_ready", edges + 2, 11);
    check("t3_retry_cleared", int'(retry_count), 0);

    // Test 2: no lock ever -> three pulses then FAIL
    pll_locked = 1'b0;
    do_reset();
    mism = 0;
    for (int k = 0; k < 96; k++) begin
      exp_rst = (k >= 72) ? 1 : (((k % 24) < 4) ? 1 : 0);
      if (int'(pll_rst) != exp_rst) mism++;
      if (k == 47) check("t2_retry_mid", int'(retry_count), 1);
      if (k == 71) check("t2_fail_before", int'(fail), 0);
      if (k == 72) check("t2_fail_at", int'(fail), 1);
      step();
    end
    check("t2_pll_rst_pattern_errors", mism, 0);
    check("t2_fail", int'(fail), 1);
    check("t2_retry", int'(retry_count), 2);
    check("t2_sys_rst", int'(sys_rst), 1);
    check("t2_ready", int'(ready), 0);

    // Test 5: reset from FAIL, then reset mid WAIT_LOCK
    do_reset();
    check_reset_values("t5_fail_reset");
    measure_pulse(len);
    check("t5_fail_pll_rst_len", len, 4);
    step(36);
    check("t5_retry_in_wait", int'(retry_count), 1);
    check("t5_in_wait", int'(pll_rst), 0);
    do_reset();
    check_reset_values("t5_wait_reset");
    measure_pulse(len);
    check("t5_wait_pll_rst_len", len, 4);

    // Test 6: lock already high during RESET_PLL
    pll_locked = 1'b1;
    do_reset();
    measure_pulse(len);
    check("t6_pll_rst_len", len, 4);
    wait_ready(edges);
    check("t6_wait_to_ready", edges, 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
